// File: rtl/soft_switch_ctrl.sv
// soft_switch_ctrl: memory-mapped I/O soft switches for $C000-$C07F.
// Provides keyboard latch/strobe, video mode switches, annunciators,
// speaker toggle, pushbutton reads and optional paddle timers.
// Optional feature macro: SOFT_SWITCH_PADDLE_EN (builds the paddle timers).

`ifdef SOFT_SWITCH_PADDLE_EN
// One paddle countdown timer: loaded on trigger, counts cpu_en ticks to zero.
module soft_switch_pdl_timer #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_busy
);

    typedef enum logic {
        PDL_IDLE  = 1'b0,
        PDL_COUNT = 1'b1
    } pdl_state_e;

    pdl_state_e       r_state;
    pdl_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // State and counter registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= PDL_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: a trigger always reloads (retrigger included); a zero load idles
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            PDL_IDLE: begin
                if (i_load && (i_load_val != '0)) begin
                    w_state_nxt = PDL_COUNT;
                    w_cnt_nxt   = i_load_val;
                end
            end
            PDL_COUNT: begin
                if (i_load) begin
                    w_cnt_nxt = i_load_val;
                    if (i_load_val == '0) begin
                        w_state_nxt = PDL_IDLE;
                    end
                end else if (i_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = PDL_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = PDL_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy = (r_state == PDL_COUNT);

endmodule
`endif

module soft_switch_ctrl #(
    parameter int unsigned PDL_SCALE = 11
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        cpu_en,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [6:0]  key_code,
    input  logic        key_valid,
    input  logic [7:0]  paddle0,
    input  logic [7:0]  paddle1,
    input  logic [1:0]  button,
    output logic [7:0]  dout,
    output logic        dout_oe,
    output logic        text_mode,
    output logic        mixed_mode,
    output logic        page2,
    output logic        hires,
    output logic [3:0]  annunciator,
    output logic        speaker,
    output logic        kbd_strobe
);

    logic       w_dec;
    logic [2:0] w_page;
    logic [3:0] w_low;
    logic       w_sw_acc;
    logic       w_ann_acc;
    logic       w_spk_acc;
    logic       w_clr_acc;
    logic       w_busy0;
    logic       w_busy1;

    logic       r_text;
    logic       r_mixed;
    logic       r_page2;
    logic       r_hires;
    logic [3:0] r_ann;
    logic       r_spk;
    logic       r_strobe;
    logic [6:0] r_key;

    assign w_dec     = cpu_en && (addr[15:7] == 9'b1100_0000_0);
    assign w_page    = addr[6:4];
    assign w_low     = addr[3:0];
    assign w_sw_acc  = w_dec && (w_page == 3'd5) && !w_low[3];
    assign w_ann_acc = w_dec && (w_page == 3'd5) &&  w_low[3];
    assign w_spk_acc = w_dec && (w_page == 3'd3);
    assign w_clr_acc = w_dec && (w_page == 3'd1);

    // Soft switches, annunciators, speaker and keyboard latch
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_text   <= 1'b1;
            r_mixed  <= 1'b0;
            r_page2  <= 1'b0;
            r_hires  <= 1'b0;
            r_ann    <= 4'h0;
            r_spk    <= 1'b0;
            r_strobe <= 1'b0;
            r_key    <= 7'h00;
        end else begin
            if (w_sw_acc) begin
                case (w_low[2:1])
                    2'd0:    r_text  <= w_low[0];
                    2'd1:    r_mixed <= w_low[0];
                    2'd2:    r_page2 <= w_low[0];
                    default: r_hires <= w_low[0];
                endcase
            end
            if (w_ann_acc) begin
                r_ann[w_low[2:1]] <= w_low[0];
            end
            if (w_spk_acc) begin
                r_spk <= ~r_spk;
            end
            // A new key wins over a coincident strobe clear
            if (key_valid) begin
                r_strobe <= 1'b1;
                r_key    <= key_code;
            end else if (w_clr_acc) begin
                r_strobe <= 1'b0;
            end
        end
    end

`ifdef SOFT_SWITCH_PADDLE_EN
    localparam int unsigned CNT_W = 12;

    logic             w_pdl_acc;
    logic [CNT_W-1:0] w_load0;
    logic [CNT_W-1:0] w_load1;

    assign w_pdl_acc = w_dec && (w_page == 3'd7);
    assign w_load0   = CNT_W'(paddle0) * CNT_W'(PDL_SCALE);
    assign w_load1   = CNT_W'(paddle1) * CNT_W'(PDL_SCALE);

    soft_switch_pdl_timer #(.CNT_W(CNT_W)) u_pdl0 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .i_tick     (cpu_en),
        .i_load     (w_pdl_acc),
        .i_load_val (w_load0),
        .o_busy     (w_busy0)
    );

    soft_switch_pdl_timer #(.CNT_W(CNT_W)) u_pdl1 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .i_tick     (cpu_en),
        .i_load     (w_pdl_acc),
        .i_load_val (w_load1),
        .o_busy     (w_busy1)
    );
`else
    logic w_unused_pdl;

    assign w_busy0      = 1'b0;
    assign w_busy1      = 1'b0;
    assign w_unused_pdl = ^{paddle0, paddle1};
`endif

    // Combinational read mux; reflects state before the ending edge
    always_comb begin
        dout    = 8'h00;
        dout_oe = 1'b0;
        if (w_dec && rw) begin
            case (w_page)
                3'd0, 3'd1: begin
                    dout    = {r_strobe, r_key};
                    dout_oe = 1'b1;
                end
                3'd6: begin
                    case (w_low)
                        4'h1: begin
                            dout    = {button[0], 7'b0};
                            dout_oe = 1'b1;
                        end
                        4'h2: begin
                            dout    = {button[1], 7'b0};
                            dout_oe = 1'b1;
                        end
                        4'h4: begin
                            dout    = {w_busy0, 7'b0};
                            dout_oe = 1'b1;
                        end
                        4'h5: begin
                            dout    = {w_busy1, 7'b0};
                            dout_oe = 1'b1;
                        end
                        default: begin
                            dout    = 8'h00;
                            dout_oe = 1'b0;
                        end
                    endcase
                end
                default: begin
                    dout    = 8'h00;
                    dout_oe = 1'b0;
                end
            endcase
        end
    end

    assign text_mode   = r_text;
    assign mixed_mode  = r_mixed;
    assign page2       = r_page2;
    assign hires       = r_hires;
    assign annunciator = r_ann;
    assign speaker     = r_spk;
    assign kbd_strobe  = r_strobe;

endmodule

// File: tb/tb_soft_switch_ctrl.sv
// Bench for soft_switch_ctrl: directed scenarios plus random traffic,
// all outputs compared every cycle against an address-range model.
// Honours SOFT_SWITCH_PADDLE_EN when the design is built with it.
module tb_soft_switch_ctrl;

    localparam int unsigned SCALE = 11;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        cpu_en;
    logic [15:0] addr;
    logic        rw;
    logic [6:0]  key_code;
    logic        key_valid;
    logic [7:0]  paddle0;
    logic [7:0]  paddle1;
    logic [1:0]  button;
    logic [7:0]  dout;
    logic        dout_oe;
    logic        text_mode;
    logic        mixed_mode;
    logic        page2;
    logic        hires;
    logic [3:0]  annunciator;
    logic        speaker;
    logic        kbd_strobe;

    soft_switch_ctrl #(.PDL_SCALE(SCALE)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .cpu_en      (cpu_en),
        .addr        (addr),
        .rw          (rw),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .paddle0     (paddle0),
        .paddle1     (paddle1),
        .button      (button),
        .dout        (dout),
        .dout_oe     (dout_oe),
        .text_mode   (text_mode),
        .mixed_mode  (mixed_mode),
        .page2       (page2),
        .hires       (hires),
        .annunciator (annunciator),
        .speaker     (speaker),
        .kbd_strobe  (kbd_strobe)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_dout;

    // Behavioural model state
    bit       m_text;
    bit       m_mixed;
    bit       m_page2;
    bit       m_hires;
    bit       m_spk;
    bit       m_strobe;
    bit [3:0] m_ann;
    bit [6:0] m_key;
    int       m_left [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_text = 1'b1; m_mixed = 1'b0; m_page2 = 1'b0; m_hires = 1'b0;
        m_spk = 1'b0; m_strobe = 1'b0; m_ann = 4'h0; m_key = 7'h00;
        m_left[0] = 0; m_left[1] = 0;
    endtask

    function automatic bit io_hit();
        return cpu_en && (addr >= 16'hC000) && (addr <= 16'hC07F);
    endfunction

    // Expected read data from the current model state and inputs
    task automatic exp_read(output logic [7:0] d, output logic oe);
        int off;
        d  = 8'h00;
        oe = 1'b0;
        if (io_hit() && rw) begin
            off = int'(addr) - 'hC000;
            if (off < 'h20) begin
                d = {m_strobe, m_key}; oe = 1'b1;
            end else if (off == 'h61) begin
                d = button[0] ? 8'h80 : 8'h00; oe = 1'b1;
            end else if (off == 'h62) begin
                d = button[1] ? 8'h80 : 8'h00; oe = 1'b1;
            end else if (off == 'h64) begin
                d = (m_left[0] > 0) ? 8'h80 : 8'h00; oe = 1'b1;
            end else if (off == 'h65) begin
                d = (m_left[1] > 0) ? 8'h80 : 8'h00; oe = 1'b1;
            end
        end
    endtask

    // Model update for one rising edge
    task automatic model_edge();
        int  off;
        bit  acc;
        acc = io_hit();
        off = int'(addr) - 'hC000;
        if (acc) begin
            if (off >= 'h50 && off <= 'h57) begin
                case ((off - 'h50) / 2)
                    0:       m_text  = (off % 2) == 1;
                    1:       m_mixed = (off % 2) == 1;
                    2:       m_page2 = (off % 2) == 1;
                    default: m_hires = (off % 2) == 1;
                endcase
            end
            if (off >= 'h58 && off <= 'h5F) m_ann[(off - 'h58) / 2] = (off % 2) == 1;
            if (off >= 'h30 && off <= 'h3F) m_spk = !m_spk;
            if (off >= 'h10 && off <= 'h1F) m_strobe = 1'b0;
        end
        if (key_valid) begin
            m_strobe = 1'b1;
            m_key    = key_code;
        end
`ifdef SOFT_SWITCH_PADDLE_EN
        for (int i = 0; i < 2; i++) begin
            if (acc && off >= 'h70) m_left[i] = int'(i == 0 ? paddle0 : paddle1) * int'(SCALE);
            else if (cpu_en && m_left[i] > 0) m_left[i]--;
        end
`endif
    endtask

    task automatic check_all();
        logic [7:0] ed;
        logic       eo;
        exp_read(ed, eo);
        last_dout = dout;
        chk("dout", 32'(dout), 32'(ed));
        chk("dout_oe", 32'(dout_oe), 32'(eo));
        chk("text_mode", 32'(text_mode), 32'(m_text));
        chk("mixed_mode", 32'(mixed_mode), 32'(m_mixed));
        chk("page2", 32'(page2), 32'(m_page2));
        chk("hires", 32'(hires), 32'(m_hires));
        chk("annunciator", 32'(annunciator), 32'(m_ann));
        chk("speaker", 32'(speaker), 32'(m_spk));
        chk("kbd_strobe", 32'(kbd_strobe), 32'(m_strobe));
    endtask

    // One clock: drive at negedge, compare, then advance model on posedge
    task automatic cycle(input logic en, input logic [15:0] a, input logic r,
                         input logic kv, input logic [6:0] kc);
        @(negedge Clk);
        cpu_en = en; addr = a; rw = r; key_valid = kv; key_code = kc;
        #1;
        check_all();
        @(posedge Clk);
        if (Reset_n) model_edge();
    endtask

    task automatic idle();
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 7'h00);
    endtask

    // Asynchronous reset pulse, optionally with a read of $C064 presented
    task automatic pulse_reset(input logic rd_pdl);
        @(negedge Clk);
        Reset_n = 1'b0;
        cpu_en = rd_pdl; addr = 16'hC064; rw = 1'b1; key_valid = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        cpu_en = 1'b0; addr = 16'h0000; rw = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        int n;
        Reset_n = 1'b0; cpu_en = 1'b0; addr = 16'h0000; rw = 1'b0;
        key_code = 7'h00; key_valid = 1'b0; paddle0 = 8'd0; paddle1 = 8'd0; button = 2'b00;
        model_reset();
        #12;
        check_all();
        chk("reset_text_lit", 32'(text_mode), 32'h1);
        chk("reset_spk_lit", 32'(speaker), 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Video switches
        cycle(1'b1, 16'hC051, 1'b1, 1'b0, 7'h00);
        cycle(1'b1, 16'hC056, 1'b0, 1'b0, 7'h00);
        idle();
        chk("text_after_c051_lit", 32'(text_mode), 32'h1);
        chk("hires_after_c056_lit", 32'(hires), 32'h0);
        cycle(1'b1, 16'hC050, 1'b1, 1'b0, 7'h00);
        idle();
        chk("text_after_c050_lit", 32'(text_mode), 32'h0);

        // Keyboard latch and strobe clear
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 7'h41);
        cycle(1'b1, 16'hC000, 1'b1, 1'b0, 7'h00);
        chk("kbd_c000_lit", 32'(last_dout), 32'hC1);
        cycle(1'b1, 16'hC010, 1'b1, 1'b0, 7'h00);
        chk("kbd_c010_lit", 32'(last_dout), 32'hC1);
        cycle(1'b1, 16'hC000, 1'b1, 1'b0, 7'h00);
        chk("kbd_after_clr_lit", 32'(last_dout), 32'h41);

        // Set wins over coincident clear
        cycle(1'b1, 16'hC010, 1'b0, 1'b1, 7'h5A);
        idle();
        chk("kbd_set_wins_lit", 32'(kbd_strobe), 32'h1);
        cycle(1'b1, 16'hC000, 1'b1, 1'b0, 7'h00);
        chk("kbd_new_key_lit", 32'(last_dout), 32'hDA);

        // Buttons
        button = 2'b10;
        cycle(1'b1, 16'hC061, 1'b1, 1'b0, 7'h00);
        chk("btn0_lit", 32'(last_dout), 32'h00);
        cycle(1'b1, 16'hC062, 1'b1, 1'b0, 7'h00);
        chk("btn1_lit", 32'(last_dout), 32'h80);

        // Paddle countdown
        paddle0 = 8'd2; paddle1 = 8'd0;
        cycle(1'b1, 16'hC070, 1'b0, 1'b0, 7'h00);
`ifdef SOFT_SWITCH_PADDLE_EN
        n = 0;
        for (int k = 0; k < 30; k++) begin
            cycle(1'b1, 16'hC064, 1'b1, 1'b0, 7'h00);
            if (last_dout == 8'h80 && k == n) n++;
        end
        chk("pdl_busy_ticks_lit", 32'(n), 32'd22);
`else
        n = 0;
        cycle(1'b1, 16'hC064, 1'b1, 1'b0, 7'h00);
        chk("pdl_absent_lit", 32'(last_dout), 32'h00);
        chk("pdl_absent_oe_lit", 32'(dout_oe), 32'h1);
`endif

        // Speaker toggles, then reset mid-countdown
        pulse_reset(1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 16'hC030, 1'b0, 1'b0, 7'h00);
        idle();
        chk("spk_three_lit", 32'(speaker), 32'h1);
        paddle0 = 8'd200;
        cycle(1'b1, 16'hC070, 1'b1, 1'b0, 7'h00);
        for (int k = 0; k < 5; k++) cycle(1'b1, 16'hC064, 1'b1, 1'b0, 7'h00);
        pulse_reset(1'b1);
        chk("spk_after_rst_lit", 32'(speaker), 32'h0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 16'hC064, 1'b1, 1'b0, 7'h00);
        chk("pdl_after_rst_lit", 32'(last_dout), 32'h00);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [15:0] a;
            if ($urandom_range(0, 9) < 8) a = 16'hC000 + 16'($urandom_range(0, 127));
            else a = 16'($urandom);
            if ($urandom_range(0, 15) == 0) paddle0 = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) paddle1 = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 63) == 0) paddle0 = 8'($urandom);
            button = 2'($urandom);
            if ($urandom_range(0, 599) == 0) pulse_reset(1'($urandom));
            cycle(1'($urandom_range(0, 9) < 7), a, 1'($urandom),
                  1'($urandom_range(0, 9) == 0), 7'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soft_switch_ctrl.md
SOFT_SWITCH_CTRL -- requirements
Module: soft_switch_ctrl

Interface
REQ-001 The block SHALL have parameter PDL_SCALE, default 11, giving cpu_en ticks per paddle count unit (legal range 1..15).
REQ-002 The block SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port cpu_en  input  1  one-Clk strobe marking the active phase of each CPU bus cycle.
REQ-005 The block SHALL have port addr  input  16  CPU address.
REQ-006 The block SHALL have port rw  input  1  1 = read, 0 = write.
REQ-007 The block SHALL have ports key_code  input  7  ASCII code, and key_valid  input  1  one-Clk new-key pulse.
REQ-008 The block SHALL have ports paddle0 and paddle1  input  8 each  paddle position values.
REQ-009 The block SHALL have port button  input  2  pushbutton levels, 1 = pressed.
REQ-010 The block SHALL have ports dout  output  8  I/O read data, and dout_oe  output  1  read data valid.
REQ-011 The block SHALL have ports text_mode, mixed_mode, page2, hires  output  1 each  video soft switches.
REQ-012 The block SHALL have ports annunciator  output  4, speaker  output  1, and kbd_strobe  output  1.

Function
REQ-013 An access SHALL be decoded only when cpu_en=1 and addr[15:7]=9'b1100_0000_0 ($C000-$C07F); soft switches, speaker and strobe clear act on both reads and writes.
REQ-014 Register updates SHALL occur on the Clk edge ending the cpu_en cycle; read data SHALL be combinational and reflect pre-update state.
REQ-015 $C050/$C051 SHALL clear/set text_mode; $C052/$C053 mixed_mode; $C054/$C055 page2; $C056/$C057 hires.
REQ-016 $C058-$C05F SHALL write annunciator[addr[2:1]] <= addr[0].
REQ-017 Each access to $C030-$C03F SHALL toggle speaker exactly once.
REQ-018 key_valid=1 SHALL latch key_code and set kbd_strobe on the same edge.
REQ-019 Reads of $C000-$C00F SHALL return {kbd_strobe, key}; any access to $C010-$C01F SHALL clear kbd_strobe, and a read there SHALL return the pre-clear {kbd_strobe, key}.
REQ-020 When key_valid coincides with a strobe-clear access, set SHALL win and the new key SHALL be latched.
REQ-021 Reads of $C061/$C062 SHALL return {button[0]/button[1], 7'b0}.
REQ-022 Each paddle timer SHALL be a two-state FSM with states IDLE and COUNT and a 12-bit counter.
REQ-023 Any access to $C070-$C07F SHALL load both counters with paddleN*PDL_SCALE and enter COUNT, including retrigger while already counting.
REQ-024 In COUNT, a timer SHALL decrement once per cpu_en and return to IDLE when it reaches 0; a load value of 0 SHALL stay in IDLE.
REQ-025 Reads of $C064/$C065 SHALL return {busy0/busy1, 7'b0}, where busy means COUNT.
REQ-026 dout_oe SHALL be 1 only for decoded reads of $C000-$C01F, $C061, $C062, $C064 and $C065; otherwise dout SHALL be 8'h00.

Reset
REQ-027 Reset_n=0 SHALL immediately force text_mode=1, mixed_mode=0, page2=0, hires=0, annunciator=4'h0, speaker=0, kbd_strobe=0, key=7'h00, both timers to IDLE with counter 0.
REQ-028 Assertion of Reset_n mid-countdown SHALL abort the countdown; after release, no state change SHALL occur before the next decoded access or key_valid.

Configuration
REQ-029 With macro SOFT_SWITCH_PADDLE_EN defined, paddle timers SHALL be built per REQ-022..REQ-025.
REQ-030 Without SOFT_SWITCH_PADDLE_EN, no timer logic SHALL exist; $C064/$C065 SHALL read 8'h00 with dout_oe=1; $C070-$C07F SHALL be ignored; paddle0/1 SHALL be unused.

Verification
REQ-031 Reset, then a read of $C051 followed by a write of $C056 -> text_mode=1, hires=0; a read of $C050 -> text_mode=0.
REQ-032 key_valid with key_code=7'h41, then read $C000 -> dout=8'hC1; read $C010 -> dout=8'hC1; a following read of $C000 -> 8'h41.
REQ-033 key_valid and a $C010 access in the same cycle -> kbd_strobe=1 and the new key is latched.
REQ-034 paddle0=8'd2, PDL_SCALE=11, access $C070 -> $C064 reads 8'h80 for exactly 22 cpu_en ticks, then reads 8'h00.
REQ-035 Three accesses to $C030 -> speaker=1; Reset_n pulsed during a paddle countdown -> speaker=0 and $C064 reads 8'h00 immediately.
